// File: rtl/key_stim_gen.sv
// Scripted push-button transmitter: turns short/long press commands into an
// active-low raw key waveform with LFSR-driven contact bounce.
module key_stim_gen #(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          SHORT_CYCLES  = 20,
  parameter int          LONG_CYCLES   = 100,
  parameter int          GAP_CYCLES    = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_long,
  input  logic bounce_en,
  output logic cmd_ready,
  output logic key_n,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {IDLE, BOUNCE_DN, HOLD, BOUNCE_UP, GAP} state_t;

  localparam bit HAS_B = (BOUNCE_CYCLES != 0);
  localparam bit HAS_G = (GAP_CYCLES != 0);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             lng_q, bnc_q, nxt_lng, nxt_bnc;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             key_d, done_d;

  // Phase order with zero-length windows removed at elaboration time.
  function automatic state_t next_phase(input state_t s);
    case (s)
      IDLE:      next_phase = HAS_B ? BOUNCE_DN : HOLD;
      BOUNCE_DN: next_phase = HOLD;
      HOLD:      next_phase = HAS_B ? BOUNCE_UP : (HAS_G ? GAP : IDLE);
      BOUNCE_UP: next_phase = HAS_G ? GAP : IDLE;
      default:   next_phase = IDLE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] last_idx(input state_t s, input logic lng);
    case (s)
      BOUNCE_DN, BOUNCE_UP: last_idx = CNT_W'(BOUNCE_CYCLES - 1);
      HOLD:                 last_idx = lng ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(SHORT_CYCLES - 1);
      GAP:                  last_idx = CNT_W'(GAP_CYCLES - 1);
      default:              last_idx = '0;
    endcase
  endfunction

  // Fibonacci taps 16,14,13,11 in right-shift form; bit 0 is the noise output.
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_lng   = lng_q;
    nxt_bnc   = bnc_q;
    if (state == IDLE) begin
      if (cmd_valid) begin
        nxt_lng   = cmd_long;
        nxt_bnc   = bounce_en;
        nxt_state = next_phase(IDLE);
        nxt_cnt   = last_idx(next_phase(IDLE), cmd_long);
      end
    end else if (cnt != '0) begin
      nxt_cnt = cnt - CNT_W'(1);
    end else begin
      nxt_state = next_phase(state);
      nxt_cnt   = last_idx(next_phase(state), lng_q);
    end
  end

  // Outputs are decided from the upcoming phase so they land registered.
  always_comb begin
    key_d = 1'b1;
    case (nxt_state)
      BOUNCE_DN: key_d = (nxt_cnt != '0) && nxt_bnc && lfsr_nxt[0];
      HOLD:      key_d = 1'b0;
      BOUNCE_UP: key_d = (nxt_cnt == '0) || !nxt_bnc || lfsr_nxt[0];
      default:   key_d = 1'b1;
    endcase
    done_d = (nxt_state != IDLE) && (nxt_cnt == '0) && (next_phase(nxt_state) == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lng_q <= 1'b0;
      bnc_q <= 1'b0;
      lfsr  <= LFSR_SEED;
      key_n <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      lng_q <= nxt_lng;
      bnc_q <= nxt_bnc;
      lfsr  <= lfsr_nxt;
      key_n <= key_d;
      done  <= done_d;
    end
  end

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_key_stim_gen.sv
// Bench for key_stim_gen: a per-cycle waveform scoreboard built from the press
// rules, plus latency / low-count checks on directed and random commands.
module tb_key_stim_gen;
  localparam int          B    = 8;
  localparam int          S    = 20;
  localparam int          L    = 100;
  localparam int          G    = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_long = 1'b0, bounce_en = 1'b0;
  logic cmd_ready, key_n, busy, done;

  key_stim_gen #(.BOUNCE_CYCLES(B), .SHORT_CYCLES(S), .LONG_CYCLES(L), .GAP_CYCLES(G),
                 .LFSR_SEED(SEED), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_long(cmd_long), .bounce_en(bounce_en),
    .cmd_ready(cmd_ready), .key_n(key_n), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // kn: 0/1 = fixed level, 2 = bounce noise (current LFSR bit 0)
  typedef struct {int kn; bit dn;} ent_t;
  ent_t        q[$];
  ent_t        cur;
  bit          cur_valid = 0;
  bit          m_acc     = 0;
  logic [15:0] m_lfsr    = SEED;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  task automatic push_seq(input bit lng, input bit bnc);
    ent_t e;
    int   h = lng ? L : S;
    e.dn = 0;
    for (int i = 0; i < B; i++) begin e.kn = (i == B-1) ? 0 : (bnc ? 2 : 0); q.push_back(e); end
    for (int i = 0; i < h; i++) begin e.kn = 0; q.push_back(e); end
    for (int i = 0; i < B; i++) begin e.kn = (i == B-1) ? 1 : (bnc ? 2 : 1); q.push_back(e); end
    for (int i = 0; i < G; i++) begin e.kn = 1; q.push_back(e); end
    q[q.size()-1].dn = 1;
  endtask

  // One clock: update the model at the edge, compare outputs on the falling edge.
  task automatic tick();
    int exp_kn;
    @(posedge clk);
    m_acc = 0;
    if (rst) begin
      q.delete();
      cur_valid = 0;
      m_lfsr = SEED;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      if (cmd_valid && !cur_valid) begin
        m_acc = 1;
        push_seq(cmd_long, bounce_en);
      end
      if (q.size() > 0) begin cur = q.pop_front(); cur_valid = 1; end
      else cur_valid = 0;
    end
    @(negedge clk);
    exp_kn = !cur_valid ? 1 : (cur.kn == 2 ? int'(m_lfsr[0]) : cur.kn);
    check("key_n", key_n, exp_kn);
    check("done", done, cur_valid && cur.dn);
    check("busy", busy, cur_valid);
    check("cmd_ready", cmd_ready, !cur_valid && !rst);
  endtask

  // Issue one command; returns accept-to-done latency and number of low cycles.
  task automatic run_cmd(input bit lng, input bit bnc, input bit keep, input int poke,
                         output int lat, output int lows);
    int n = 0;
    cmd_long = lng; bounce_en = bnc; cmd_valid = 1;
    do begin tick(); n++; end while (!m_acc && n < 20);
    check("accept", m_acc, 1);
    lat = 1;
    lows = (key_n == 0) ? 1 : 0;
    while (!done && lat < 400) begin
      cmd_valid = keep || (lat == poke);
      cmd_long = $urandom_range(0, 1);
      bounce_en = $urandom_range(0, 1);
      tick();
      lat++;
      if (key_n == 0) lows++;
    end
  endtask

  initial begin
    int lat, lows, n, nd;
    for (int i = 0; i < 3; i++) tick();
    rst = 0;
    tick();

    // short press, clean windows
    run_cmd(0, 0, 0, 0, lat, lows);
    check("short_latency", lat, 2*B + S + G);
    check("short_lows", lows, B + S);
    cmd_valid = 0;
    tick();

    // long press with bounce noise
    run_cmd(1, 1, 0, 0, lat, lows);
    check("long_latency", lat, 2*B + L + G);
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) tick();

    // busy poke during HOLD is ignored
    run_cmd(0, 1, 0, B + 5, lat, lows);
    check("poke_latency", lat, 2*B + S + G);
    cmd_valid = 0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (done) nd++; end
    check("poke_extra_done", nd, 0);

    // back-to-back with cmd_valid held
    run_cmd(0, 0, 1, 0, lat, lows);
    n = 0;
    do begin tick(); n++; end while (!m_acc && n < 10);
    check("b2b_accept_gap", n, 2);
    cmd_valid = 0;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    check("b2b_second_done", done, 1);
    tick();

    // reset in the middle of HOLD
    cmd_long = 0; bounce_en = 1; cmd_valid = 1;
    n = 0;
    do begin tick(); n++; end while (!m_acc && n < 20);
    cmd_valid = 0;
    for (int i = 0; i < B + 4; i++) tick();
    rst = 1;
    tick();
    check("rst_key_n", key_n, 1);
    tick();
    rst = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) nd++; end
    check("rst_no_done", nd, 0);
    run_cmd(1, 1, 0, 0, lat, lows);
    check("post_rst_latency", lat, 2*B + L + G);
    cmd_valid = 0;

    // random commands with random idle gaps and busy pokes
    for (int k = 0; k < 6; k++) begin
      bit rl, rb;
      int h;
      rl = $urandom_range(0, 1);
      rb = $urandom_range(0, 1);
      h = rl ? L : S;
      cmd_valid = 0;
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) tick();
      run_cmd(rl, rb, 0, $urandom_range(0, 30), lat, lows);
      check("rand_latency", lat, 2*B + h + G);
      if (!rb) check("rand_lows", lows, B + h);
      cmd_valid = 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
